// File: rtl/term_pkg.sv
// Shared definitions for the terminal receive path: command opcodes,
// parser state encoding, control byte values and CSI parameter arithmetic.
package term_pkg;

   localparam logic [2:0] CMD_PUTC  = 3'd0;
   localparam logic [2:0] CMD_CR    = 3'd1;
   localparam logic [2:0] CMD_LF    = 3'd2;
   localparam logic [2:0] CMD_BS    = 3'd3;
   localparam logic [2:0] CMD_CUP   = 3'd4;
   localparam logic [2:0] CMD_CLEAR = 3'd5;

   typedef enum logic [1:0] {
      ST_GROUND,
      ST_ESC,
      ST_CSI
   } parseState_e;

   localparam logic [7:0] CH_ESC = 8'h1B;
   localparam logic [7:0] CH_CAN = 8'h18;
   localparam logic [7:0] CH_SUB = 8'h1A;
   localparam logic [7:0] CH_CR  = 8'h0D;
   localparam logic [7:0] CH_LF  = 8'h0A;
   localparam logic [7:0] CH_BS  = 8'h08;

   // P*10 + digit, saturating at 255; anything above 25 already overflows.
   function automatic logic [7:0] paramAccum(input logic [7:0] p, input logic [3:0] digit);
      logic [8:0] acc;
      if (p > 8'd25) begin
         paramAccum = 8'hFF;
      end else begin
         acc = ({1'b0, p} * 9'd10) + {5'b0, digit};
         paramAccum = (acc > 9'd255) ? 8'hFF : acc[7:0];
      end
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with wrap-bit pointers. A push on a full FIFO is
// accepted only when a pop happens in the same cycle.
module byte_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wrPtr_q, wrPtr_d;
   logic [AW:0]      rdPtr_q, rdPtr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             pushEn;
   logic             popEn;

   assign empty_o = (wrPtr_q == rdPtr_q);
   assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
   assign popEn   = pop_i && !empty_o;
   assign pushEn  = push_i && (!full_o || popEn);
   assign data_o  = mem_q[rdPtr_q[AW-1:0]];

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      if (pushEn) wrPtr_d = wrPtr_q + 1'b1;
      if (popEn)  rdPtr_d = rdPtr_q + 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
      end
   end

   // Storage needs no reset; emptiness is decided by the pointers alone.
   always_ff @(posedge clk_i) begin
      if (pushEn) mem_q[wrPtr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/term_cmd_decoder.sv
// Buffers UART receive bytes and parses a VT100 subset into display
// commands presented on a registered valid/ready output.
module term_cmd_decoder
   import term_pkg::*;
#(
   parameter int FIFO_DEPTH = 16
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_RX_DV,
   input  logic [7:0] i_RX_Byte,
   input  logic       i_Ready,
   output logic       o_Cmd_Valid,
   output logic [2:0] o_Cmd,
   output logic [7:0] o_Char,
   output logic [7:0] o_Arg0,
   output logic [7:0] o_Arg1,
   output logic       o_Overrun
);

   logic [7:0]  fifoData;
   logic        fifoFull;
   logic        fifoEmpty;
   logic        slotFree;
   logic        pop;

   parseState_e state_q, state_d;
   logic [7:0]  p0_q, p0_d, p1_q, p1_d;
   logic [1:0]  idx_q, idx_d;
   logic        seen0_q, seen0_d, seen1_q, seen1_d;

   logic        valid_q, valid_d;
   logic [2:0]  cmd_q, cmd_d;
   logic [7:0]  char_q, char_d, arg0_q, arg0_d, arg1_q, arg1_d;
   logic        overrun_q, overrun_d;

   logic        emit;
   logic [2:0]  emitCmd;
   logic [7:0]  emitChar, emitArg0, emitArg1;

   assign slotFree = !valid_q || i_Ready;
   assign pop      = !fifoEmpty && slotFree;

   byte_fifo #(
      .WIDTH(8),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk_i  (i_Clock),
      .rst_i  (i_Reset),
      .push_i (i_RX_DV),
      .pop_i  (pop),
      .data_i (i_RX_Byte),
      .data_o (fifoData),
      .full_o (fifoFull),
      .empty_o(fifoEmpty)
   );

   always_comb begin
      state_d   = state_q;
      p0_d      = p0_q;
      p1_d      = p1_q;
      idx_d     = idx_q;
      seen0_d   = seen0_q;
      seen1_d   = seen1_q;
      emit      = 1'b0;
      emitCmd   = CMD_PUTC;
      emitChar  = 8'h00;
      emitArg0  = 8'h00;
      emitArg1  = 8'h00;

      if (pop) begin
         unique case (state_q)
            ST_GROUND: begin
               if (fifoData >= 8'h20 && fifoData <= 8'h7E) begin
                  emit     = 1'b1;
                  emitCmd  = CMD_PUTC;
                  emitChar = fifoData;
               end else if (fifoData == CH_CR) begin
                  emit    = 1'b1;
                  emitCmd = CMD_CR;
               end else if (fifoData == CH_LF) begin
                  emit    = 1'b1;
                  emitCmd = CMD_LF;
               end else if (fifoData == CH_BS) begin
                  emit    = 1'b1;
                  emitCmd = CMD_BS;
               end else if (fifoData == CH_ESC) begin
                  state_d = ST_ESC;
               end
            end
            ST_ESC: begin
               if (fifoData == 8'h5B) begin
                  state_d = ST_CSI;
                  p0_d    = 8'h00;
                  p1_d    = 8'h00;
                  idx_d   = 2'd0;
                  seen0_d = 1'b0;
                  seen1_d = 1'b0;
               end else if (fifoData != CH_ESC) begin
                  state_d = ST_GROUND;
               end
            end
            ST_CSI: begin
               if (fifoData == CH_ESC) begin
                  state_d = ST_ESC;
               end else if (fifoData == CH_CAN || fifoData == CH_SUB) begin
                  state_d = ST_GROUND;
               end else if (fifoData >= 8'h30 && fifoData <= 8'h39) begin
                  if (idx_q == 2'd0) begin
                     p0_d    = paramAccum(p0_q, fifoData[3:0]);
                     seen0_d = 1'b1;
                  end else if (idx_q == 2'd1) begin
                     p1_d    = paramAccum(p1_q, fifoData[3:0]);
                     seen1_d = 1'b1;
                  end
               end else if (fifoData == 8'h3B) begin
                  // Index saturates at 2, meaning "beyond the two tracked params".
                  if (idx_q != 2'd2) idx_d = idx_q + 2'd1;
               end else if (fifoData == 8'h48 || fifoData == 8'h66) begin
                  emit     = 1'b1;
                  emitCmd  = CMD_CUP;
                  emitArg0 = (!seen0_q || p0_q == 8'h00) ? 8'd1 : p0_q;
                  emitArg1 = (!seen1_q || p1_q == 8'h00) ? 8'd1 : p1_q;
                  state_d  = ST_GROUND;
               end else if (fifoData == 8'h4A) begin
                  emit    = seen0_q && (p0_q == 8'd2);
                  emitCmd = CMD_CLEAR;
                  state_d = ST_GROUND;
               end else if (fifoData >= 8'h40 && fifoData <= 8'h7E) begin
                  state_d = ST_GROUND;
               end
            end
            default: state_d = ST_GROUND;
         endcase
      end
   end

   // Output slot: cleared on acceptance, reloaded whenever a decode emits.
   always_comb begin
      valid_d   = valid_q;
      cmd_d     = cmd_q;
      char_d    = char_q;
      arg0_d    = arg0_q;
      arg1_d    = arg1_q;
      overrun_d = overrun_q || (i_RX_DV && fifoFull && !pop);
      if (valid_q && i_Ready) begin
         valid_d = 1'b0;
         cmd_d   = 3'd0;
         char_d  = 8'h00;
         arg0_d  = 8'h00;
         arg1_d  = 8'h00;
      end
      if (emit) begin
         valid_d = 1'b1;
         cmd_d   = emitCmd;
         char_d  = emitChar;
         arg0_d  = emitArg0;
         arg1_d  = emitArg1;
      end
   end

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state_q   <= ST_GROUND;
         p0_q      <= 8'h00;
         p1_q      <= 8'h00;
         idx_q     <= 2'd0;
         seen0_q   <= 1'b0;
         seen1_q   <= 1'b0;
         valid_q   <= 1'b0;
         cmd_q     <= 3'd0;
         char_q    <= 8'h00;
         arg0_q    <= 8'h00;
         arg1_q    <= 8'h00;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         p0_q      <= p0_d;
         p1_q      <= p1_d;
         idx_q     <= idx_d;
         seen0_q   <= seen0_d;
         seen1_q   <= seen1_d;
         valid_q   <= valid_d;
         cmd_q     <= cmd_d;
         char_q    <= char_d;
         arg0_q    <= arg0_d;
         arg1_q    <= arg1_d;
         overrun_q <= overrun_d;
      end
   end

   assign o_Cmd_Valid = valid_q;
   assign o_Cmd       = cmd_q;
   assign o_Char      = char_q;
   assign o_Arg0      = arg0_q;
   assign o_Arg1      = arg1_q;
   assign o_Overrun   = overrun_q;

endmodule

// File: doc/term_cmd_decoder.md
# term_cmd_decoder

Receive-side command decoder for the terminal: consumes bytes strobed out of the UART receiver (`o_RX_DV` / `o_RX_Byte`) and turns them into display commands for the screen-buffer writer. Incoming bytes are buffered in a small FIFO, because the UART has no backpressure. A VT100-subset escape parser then emits one command per completed sequence over a valid/ready handshake.

## Interface
- `FIFO_DEPTH`, default 16: input FIFO entries; power of 2, minimum 2.
- `i_Clock` in 1: system clock, same domain as the UART receiver.
- `i_Reset` in 1: asynchronous, active-high reset.
- `i_RX_DV` in 1: one-cycle byte strobe, connected to the receiver `o_RX_DV`.
- `i_RX_Byte` in 8: received byte, valid when `i_RX_DV` is high.
- `i_Ready` in 1: downstream accepts the command this cycle.
- `o_Cmd_Valid` out 1: a command is presented.
- `o_Cmd` out 3: opcode.
  - PUTC=0, CR=1, LF=2, BS=3, CUP=4, CLEAR=5.
- `o_Char` out 8: character for PUTC, otherwise 0.
- `o_Arg0` out 8: CUP row (1-based), otherwise 0.
- `o_Arg1` out 8: CUP column (1-based), otherwise 0.
- `o_Overrun` out 1: sticky flag; set when a byte is dropped on a full FIFO.

## Operation
- **FIFO push.** A push happens on every cycle with `i_RX_DV` high.
  - If the FIFO is full and no pop occurs that cycle, the byte is dropped and `o_Overrun` is set.
  - `o_Overrun` stays set until reset.
  - Push and pop in the same cycle on a full FIFO: both succeed.
- **FIFO pop.** The parser pops one byte per cycle when the FIFO is non-empty and the output slot is free. The slot is free when `o_Cmd_Valid` is low, or when `o_Cmd_Valid` and `i_Ready` are both high.
- **GROUND state.**
  - 0x20–0x7E → PUTC.
  - 0x0D → CR.
  - 0x0A → LF.
  - 0x08 → BS.
  - 0x1B → ESC state.
  - All other bytes are dropped.
- **ESC state.**
  - '[' → CSI state: clears P0 and P1, sets param index to 0, clears both "seen" flags.
  - 0x1B stays in ESC.
  - Anything else is dropped and the parser returns to GROUND.
- **CSI state.**
  - **Digits.** '0'–'9' update the current param as P = P*10 + digit. Arithmetic is 9-bit internally and saturates at 255. The digit sets that param's "seen" flag.
  - **';'** increments the param index. Indices above 1 are accepted, but their digits are ignored.
  - **'H' or 'f'** → CUP, then GROUND.
    - Row = P0, column = P1.
    - A param that is not seen, or equals 0, becomes 1.
  - **'J'** → CLEAR only when P0 = 2 and P0 was seen. In all cases the parser returns to GROUND.
  - **Other final bytes 0x40–0x7E:** dropped, return to GROUND.
  - **0x1B:** go to ESC.
  - **0x18 or 0x1A:** abort to GROUND.
  - **Other bytes:** ignored; the parser stays in CSI.
- **Command output.** Fields are registered together with `o_Cmd_Valid` and hold stable until accepted. Unused fields read 0.

## Timing
- **Reset values.**
  - `o_Cmd_Valid`=0, `o_Cmd`=0, `o_Char`=0, `o_Arg0`=0, `o_Arg1`=0, `o_Overrun`=0.
  - FIFO is empty; parser is in GROUND.
- **Reset mid-operation.** Reset during a sequence or with commands pending discards everything. There are no outputs until new bytes arrive.
- **Latency.** `i_RX_DV` is sampled at edge k and the byte is stored. The byte is popped and decoded at edge k+1. `o_Cmd_Valid` is high after edge k+1, assuming the FIFO was empty and the slot free.
- **Throughput.** One byte per cycle. With `i_Ready` held high, back-to-back commands issue on consecutive cycles.
- **Handshake.** A command transfers on any cycle with `o_Cmd_Valid` and `i_Ready` both high. `i_Ready` may be high while `o_Cmd_Valid` is low; this has no effect.
- **Empty FIFO.** No pop occurs and the parser state is held.
- **Wrap-around.** FIFO pointers are log2(FIFO_DEPTH)+1 bits. Full = MSBs differ and the low bits are equal. Empty = pointers equal.

## Structure
- `term_pkg` holds:
  - the opcode localparams (`CMD_PUTC`..`CMD_CLEAR`);
  - the parser state encoding (GROUND, ESC, CSI);
  - control byte constants: ESC 0x1B, CAN 0x18, SUB 0x1A, CR, LF, BS.
- Sub-module `byte_fifo` (parameters WIDTH and DEPTH): push, pop, full, empty, head data. `term_cmd_decoder` instantiates it once.
- The parser FSM and the output register live in the top.

## Test plan
- **Plain text.** Send "Hi\r\n" with `i_Ready`=1 → PUTC 'H', PUTC 'i', CR, LF on four consecutive valid cycles. First valid is 2 edges after the first DV.
- **Cursor position.** Send ESC "[12;40H" → one CUP with Arg0=12, Arg1=40. ESC "[H" → CUP 1,1. ESC "[0;5f" → CUP 1,5. ESC "[999;3H" → CUP 255,3.
- **Clear screen.** Send ESC "[2J" → CLEAR. ESC "[J" → no command. ESC "[1J" → no command. ESC "[2X" → no command, then 'A' → PUTC 'A'.
- **Aborts.** Send ESC "[12" 0x18 'B' → PUTC 'B' only. ESC "[3" ESC "[4;4H" → CUP 4,4.
- **Backpressure and overrun.** With FIFO_DEPTH=4 and `i_Ready`=0, push "ABCDEF":
  - one command is held (A) and 4 bytes are buffered (B–E);
  - 'F' is dropped and `o_Overrun`=1.
  - Raise `i_Ready` → A, B, C, D, E in order.
  - Apply reset → all outputs 0.
- **Simultaneous push/pop.** Fill the FIFO, then on the same cycle pulse `i_RX_DV` with 'Z' and accept a command. 'Z' is retained and `o_Overrun` stays 0.
